// File: rtl/fir_mac_sequencer.sv
// Time-multiplexed FIR controller: TAPS-deep delay line, coefficient regfile
// and one shared signed MAC, with round-half-up and saturation to n bits.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for in_valid; accepts samples and coefficient writes
// MAC   | one tap per cycle: acc += d[idx] * coef[idx]
// ROUND | round, saturate and register out; pulse out_valid
module fir_mac_sequencer #(
    parameter int n    = 12,
    parameter int TAPS = 8,
    parameter int CW   = 12,
    parameter int AW   = $clog2(TAPS),
    parameter int ACCW = n + CW + $clog2(TAPS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [n-1:0]  in,
    output logic [n-1:0]  out,
    output logic          out_valid,
    output logic          busy,
    output logic          overrun,
    input  logic          cfg_we,
    input  logic [AW-1:0] cfg_addr,
    input  logic [CW-1:0] cfg_data,
    output logic          cfg_err,
    input  logic          flag_clr
);

    typedef enum logic [1:0] {IDLE, MAC, ROUND} state_t;

    localparam logic signed [CW-1:0] COEF_ONE = CW'((1 << (CW - 1)) - 1);
    localparam logic signed [ACCW:0] RND_BIAS = (ACCW + 1)'(1 << (CW - 2));
    localparam logic signed [ACCW:0] SMAX     = (ACCW + 1)'((1 << (n - 1)) - 1);
    localparam logic signed [ACCW:0] SMIN     = ~SMAX;

    state_t                 state;
    logic signed [n-1:0]    d    [TAPS];
    logic signed [CW-1:0]   coef [TAPS];
    logic [AW-1:0]          idx;
    logic signed [ACCW-1:0] acc;

    logic signed [n+CW-1:0] prod;
    logic signed [ACCW:0]   rnd;
    logic signed [ACCW:0]   shr;
    logic [n-1:0]           sat;
    logic                   addr_ok;

    // With a power-of-two depth every address is a real tap.
    if ((1 << AW) == TAPS) begin : g_addr_pow2
        assign addr_ok = 1'b1;
    end else begin : g_addr_npow2
        assign addr_ok = (cfg_addr < AW'(TAPS));
    end

    assign prod = d[idx] * coef[idx];

    always_comb begin
        rnd = (ACCW + 1)'(acc) + RND_BIAS;
        shr = rnd >>> (CW - 1);
        if (shr > SMAX)
            sat = SMAX[n-1:0];
        else if (shr < SMIN)
            sat = SMIN[n-1:0];
        else
            sat = shr[n-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            out       <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            overrun   <= 1'b0;
            cfg_err   <= 1'b0;
            idx       <= '0;
            acc       <= '0;
            for (int k = 0; k < TAPS; k++) begin
                d[k]    <= '0;
                coef[k] <= (k == 0) ? COEF_ONE : '0;
            end
        end else begin
            out_valid <= 1'b0;

            // Clear first so a same-cycle set takes priority.
            if (flag_clr) begin
                overrun <= 1'b0;
                cfg_err <= 1'b0;
            end
            if (in_valid && busy)
                overrun <= 1'b1;
            if (cfg_we && (busy || !addr_ok))
                cfg_err <= 1'b1;
            if (cfg_we && !busy && addr_ok)
                coef[cfg_addr] <= cfg_data;

            case (state)
                IDLE: begin
                    if (in_valid) begin
                        d[0] <= in;
                        for (int k = 1; k < TAPS; k++)
                            d[k] <= d[k-1];
                        acc   <= '0;
                        idx   <= '0;
                        busy  <= 1'b1;
                        state <= MAC;
                    end
                end
                MAC: begin
                    acc <= acc + ACCW'(prod);
                    idx <= idx + AW'(1);
                    if (idx == AW'(TAPS - 1))
                        state <= ROUND;
                end
                ROUND: begin
                    out       <= sat;
                    out_valid <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Directed bench for fir_mac_sequencer (n=12, TAPS=8, CW=12); inputs are
// driven and outputs sampled on the falling clock edge.
module tb_fir_mac_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [11:0] din;
    logic [11:0] dout;
    logic        out_valid;
    logic        busy;
    logic        overrun;
    logic        cfg_we;
    logic [2:0]  cfg_addr;
    logic [11:0] cfg_data;
    logic        cfg_err;
    logic        flag_clr;

    int tests_run = 0;
    int failures  = 0;

    fir_mac_sequencer dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in       (din),
        .out      (dout),
        .out_valid(out_valid),
        .busy     (busy),
        .overrun  (overrun),
        .cfg_we   (cfg_we),
        .cfg_addr (cfg_addr),
        .cfg_data (cfg_data),
        .cfg_err  (cfg_err),
        .flag_clr (flag_clr)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, summary not printed");
        $fatal(1, "watchdog");
    end

    task automatic tick_neg;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset;
        rst = 1'b1;
        tick_neg();
        rst = 1'b0;
    endtask

    task automatic cfg_write(input int a, input int v);
        cfg_we   = 1'b1;
        cfg_addr = a[2:0];
        cfg_data = v[11:0];
        tick_neg();
        cfg_we   = 1'b0;
    endtask

    // Accepts one sample, then watches 20 cycles. inj_c/inj_kind optionally
    // disturb cycle inj_c: 1=in_valid, 2=cfg_we coef0<=0, 3=in_valid+flag_clr, 4=rst.
    task automatic run_sample(input int v, input int inj_c, input int inj_kind,
                              output int res, output int lat,
                              output int busy_hi, output int nvalid);
        din      = v[11:0];
        in_valid = 1'b1;
        tick_neg();
        in_valid = 1'b0;
        cfg_we   = 1'b0;
        res      = 0;
        lat      = -1;
        busy_hi  = 0;
        nvalid   = 0;
        for (int c = 1; c <= 20; c++) begin
            if (c == inj_c) begin
                case (inj_kind)
                    1: begin in_valid = 1'b1; din = 12'd777; end
                    2: begin cfg_we = 1'b1; cfg_addr = 3'd0; cfg_data = 12'd0; end
                    3: begin in_valid = 1'b1; din = 12'd777; flag_clr = 1'b1; end
                    4: rst = 1'b1;
                    default: ;
                endcase
            end
            tick_neg();
            in_valid = 1'b0;
            cfg_we   = 1'b0;
            flag_clr = 1'b0;
            rst      = 1'b0;
            if (busy) busy_hi++;
            if (out_valid) begin
                nvalid++;
                if (lat < 0) begin
                    lat = c;
                    res = int'($signed(dout));
                end
            end
        end
    endtask

    task automatic test_reset;
        int res, lat, bh, nv;
        do_reset();
        tests_run++;
        if ({dout, out_valid, busy, overrun, cfg_err} !== 16'h0) begin
            failures++;
            $display("FAIL reset_state: got out=%0d ov=%b busy=%b orun=%b cerr=%b, want all 0",
                     dout, out_valid, busy, overrun, cfg_err);
        end
        run_sample(1000, 0, 0, res, lat, bh, nv);
        tests_run++;
        if (lat !== 9) begin
            failures++;
            $display("FAIL latency: got %0d want 9", lat);
        end
        tests_run++;
        if (res !== 1000) begin
            failures++;
            $display("FAIL unity_out: got %0d want 1000", res);
        end
        tests_run++;
        if (bh !== 8 || nv !== 1) begin
            failures++;
            $display("FAIL busy_window: got busy_cycles=%0d valids=%0d want 8 and 1", bh, nv);
        end
        tests_run++;
        if ($signed(dout) !== 12'sd1000) begin
            failures++;
            $display("FAIL out_hold: got %0d want 1000", $signed(dout));
        end
    endtask

    task automatic test_impulse;
        int res, lat, bh, nv;
        int exp_v [3] = '{0, 0, 1000};
        int in_v  [3] = '{1000, 0, 0};
        do_reset();
        cfg_write(0, 0);
        cfg_write(2, 2047);
        for (int i = 0; i < 3; i++) begin
            run_sample(in_v[i], 0, 0, res, lat, bh, nv);
            tests_run++;
            if (res !== exp_v[i] || nv !== 1) begin
                failures++;
                $display("FAIL impulse[%0d]: got %0d (valids=%0d) want %0d", i, res, nv, exp_v[i]);
            end
        end
    endtask

    task automatic test_saturation;
        int res, lat, bh, nv;
        do_reset();
        cfg_write(1, 2047);
        run_sample(2047, 0, 0, res, lat, bh, nv);
        run_sample(2047, 0, 0, res, lat, bh, nv);
        tests_run++;
        if (res !== 2047) begin
            failures++;
            $display("FAIL sat_pos: got %0d want 2047", res);
        end
        run_sample(-2048, 0, 0, res, lat, bh, nv);
        run_sample(-2048, 0, 0, res, lat, bh, nv);
        tests_run++;
        if (res !== -2048) begin
            failures++;
            $display("FAIL sat_neg: got %0d want -2048", res);
        end
    endtask

    task automatic test_overrun;
        int res, lat, bh, nv;
        do_reset();
        cfg_write(0, 0);
        cfg_write(2, 2047);
        run_sample(1000, 3, 1, res, lat, bh, nv);
        tests_run++;
        if (overrun !== 1'b1 || nv !== 1 || res !== 0) begin
            failures++;
            $display("FAIL overrun_set: got orun=%b valids=%0d out=%0d want 1,1,0", overrun, nv, res);
        end
        // Clear racing a fresh overrun: the set must win.
        run_sample(0, 4, 3, res, lat, bh, nv);
        tests_run++;
        if (res !== 0 || overrun !== 1'b1) begin
            failures++;
            $display("FAIL overrun_line: got out=%0d orun=%b want 0 and 1", res, overrun);
        end
        run_sample(0, 0, 0, res, lat, bh, nv);
        tests_run++;
        if (res !== 1000) begin
            failures++;
            $display("FAIL overrun_tap2: got %0d want 1000", res);
        end
        flag_clr = 1'b1;
        tick_neg();
        flag_clr = 1'b0;
        tests_run++;
        if (overrun !== 1'b0) begin
            failures++;
            $display("FAIL overrun_clr: got %b want 0", overrun);
        end
    endtask

    task automatic test_cfg_collision;
        int res, lat, bh, nv;
        do_reset();
        run_sample(1000, 2, 2, res, lat, bh, nv);
        tests_run++;
        if (cfg_err !== 1'b1 || res !== 1000) begin
            failures++;
            $display("FAIL cfg_busy: got cerr=%b out=%0d want 1 and 1000", cfg_err, res);
        end
        // Two 1000 samples with coef0 kept and coef1=0 still give 1000.
        run_sample(1000, 0, 0, res, lat, bh, nv);
        tests_run++;
        if (res !== 1000) begin
            failures++;
            $display("FAIL cfg_unchanged: got %0d want 1000", res);
        end
        do_reset();
        cfg_we   = 1'b1;
        cfg_addr = 3'd0;
        cfg_data = 12'd1024;
        run_sample(1000, 0, 0, res, lat, bh, nv);
        tests_run++;
        if (res !== 500 || cfg_err !== 1'b0) begin
            failures++;
            $display("FAIL cfg_same_edge: got out=%0d cerr=%b want 500 and 0", res, cfg_err);
        end
    endtask

    task automatic test_reset_mid;
        int res, lat, bh, nv;
        do_reset();
        run_sample(1000, 0, 0, res, lat, bh, nv);
        run_sample(1000, 5, 4, res, lat, bh, nv);
        tests_run++;
        if (nv !== 0 || dout !== 12'd0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid: got valids=%0d out=%0d busy=%b want 0,0,0", nv, dout, busy);
        end
        run_sample(1000, 0, 0, res, lat, bh, nv);
        tests_run++;
        if (res !== 1000 || lat !== 9) begin
            failures++;
            $display("FAIL reset_recover: got out=%0d lat=%0d want 1000 and 9", res, lat);
        end
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        din      = '0;
        cfg_we   = 1'b0;
        cfg_addr = '0;
        cfg_data = '0;
        flag_clr = 1'b0;
        @(negedge clk);
        test_reset();
        test_impulse();
        test_saturation();
        test_overrun();
        test_cfg_collision();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule

// File: doc/fir_mac_sequencer.md
Name: fir_mac_sequencer

Overview:
- Time-multiplexed FIR filter controller for the synthesizer FILTER path.
- Owns a TAPS-deep unit-delay (z^-1) sample line, a coefficient register file and a single shared signed multiply-accumulate unit.
- Sequences the MAC across all taps once per accepted input sample, then rounds and saturates the result to the output width.
- Sits between the DDS sample source and the audio output stage; coefficients are loaded through a simple config write port.

Parameters:
- n, 12, sample bitwidth (signed two's complement).
- TAPS, 8, number of taps / delay-line depth (≥2).
- CW, 12, coefficient bitwidth (signed Q1.(CW-1)).
- AW, $clog2(TAPS), coefficient address width.
- ACCW, n+CW+$clog2(TAPS), accumulator width.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous active-high reset
- in_valid  input  1  single-cycle sample strobe
- in  input  n  signed input sample, sampled when in_valid accepted
- out  output  n  signed filtered sample, registered, held until next result
- out_valid  output  1  one-cycle pulse when out updates
- busy  output  1  high while a sample is being processed
- overrun  output  1  sticky: in_valid arrived while busy (sample dropped)
- cfg_we  input  1  coefficient write enable
- cfg_addr  input  AW  coefficient index (0 = newest sample tap)
- cfg_data  input  CW  signed coefficient value
- cfg_err  output  1  sticky: cfg_we arrived while busy (write dropped)
- flag_clr  input  1  clears overrun and cfg_err

Behaviour:
- Reset: synchronous on rst=1 at the clock edge. Reset values:
  - out=0, out_valid=0, busy=0, overrun=0, cfg_err=0, state=IDLE.
  - All delay-line entries d[0..TAPS-1] = 0.
  - coef[0] = 2^(CW-1)-1 (≈1.0); all other coefficients = 0.
  - Reset mid-computation aborts it: no out_valid is produced and out returns to 0.
- FSM states:
  - IDLE: busy=0. On in_valid: d[0]<=in and d[k]<=d[k-1] for k≥1; acc<=0; idx<=0; go to MAC.
  - MAC: busy=1. Each cycle: acc <= acc + d[idx]*coef[idx] (signed, full ACCW precision, no intermediate saturation); idx++. When idx==TAPS-1, the final accumulate happens and the FSM goes to ROUND.
  - ROUND: busy=1. out <= sat_n((acc + 2^(CW-2)) >>> (CW-1)), i.e. round half up, arithmetic shift. out_valid<=1 for exactly this one edge. Go to IDLE.
- Saturation: clamp to [-2^(n-1), 2^(n-1)-1].
- Latency: if in_valid is accepted at edge E, MAC runs on edges E+1..E+TAPS, and out/out_valid are registered at edge E+TAPS+1.
- Throughput: the earliest next acceptance is edge E+TAPS+2. Only the IDLE state accepts samples.
- in_valid while busy=1: the sample is dropped, overrun<=1, and the delay line is untouched.
- Config writes:
  - cfg_we in IDLE: coef[cfg_addr]<=cfg_data.
  - cfg_we while busy: the write is ignored and cfg_err<=1.
  - cfg_we together with in_valid in IDLE: both take effect at the same edge, and that sample's computation uses the new coefficient.
  - cfg_addr ≥ TAPS (non-power-of-2 TAPS): the write is ignored and cfg_err<=1.
- Sticky flags:
  - flag_clr clears overrun and cfg_err.
  - If a flag's set condition and flag_clr occur in the same cycle, the set wins.
- out_valid is deasserted in every cycle other than the ROUND edge.
- out holds its value between results.

Test Plan:
- Reset, then in=1000 pulse: out_valid exactly 9 cycles after acceptance (TAPS=8) with out=1000; busy high for those cycles.
- Impulse response:
  - Write coef[0]=0 and coef[2]=2047.
  - Feed in=1000, then 0, then 0, each in IDLE.
  - Required outputs: 0, 0, 1000.
- Positive saturation:
  - Write coef[0]=coef[1]=2047.
  - Feed 2047 twice.
  - Second out=2047 (unclamped value 4092).
  - Feed -2048 twice with the same coefficients: second out=-2048.
- Overrun:
  - Pulse in_valid 3 cycles after an accepted sample.
  - Required: overrun=1, delay line unchanged (next impulse test output unaffected), exactly one out_valid.
  - Then flag_clr: overrun=0.
- Config collisions:
  - cfg_we during MAC sets cfg_err=1 and the coefficient is unchanged.
  - cfg_we to coef[0]=1024 with in_valid in=1000 in the same IDLE cycle: out=500.
- Reset mid-operation: assert rst 4 cycles into MAC. Required: no out_valid, out=0, busy=0, and a subsequent in=1000 gives out=1000.
